// File: rtl/pipe_pkg.sv
// Shared constants for the fetch/decode front end: NOP encoding, PC step,
// register-field positions and the bubble control value.
package pipe_pkg;
  localparam int unsigned NOP_INSTR   = 0;
  localparam int unsigned PC_INC      = 4;
  localparam int unsigned RS_HI       = 25;
  localparam int unsigned RS_LO       = 21;
  localparam int unsigned RT_HI       = 20;
  localparam int unsigned RT_LO       = 16;
  localparam int unsigned CTRL_BUBBLE = 0;
endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-high reset, synchronous clear
// (dominates enable), load on enable, otherwise hold.
module pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule

// File: rtl/fetch_decode_pipe.sv
// Pipeline front end: PC, IF/ID and ID/EX registers driven by the hazard unit.
// Optional stall counter and stall_count port exist only with STALL_COUNTER_EN.
module fetch_decode_pipe
  import pipe_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int REG_W   = 8,
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               stall_insert,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic               id_mem_read,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [REG_W-1:0]   ifid_rs,
  output logic [REG_W-1:0]   ifid_rt,
  output logic [REG_W-1:0]   idex_rt,
  output logic               idex_mem_read,
  output logic [CTRL_W-1:0]  idex_ctrl,
  output logic               idex_valid
`ifdef STALL_COUNTER_EN
  ,
  output logic [CNT_W-1:0]   stall_count
`endif
);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } ifid_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              mem_read;
    logic [REG_W-1:0]  rt;
    logic              valid;
  } idex_t;

  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  ifid_t           ifid_q, ifid_d;
  idex_t           idex_q, idex_d;
  logic            idex_bubble;

  assign pc_plus4 = pc_q + PC_W'(PC_INC);
  assign pc_d     = flush ? branch_target : pc_plus4;

  pipe_reg #(.W(PC_W)) u_pc (
    .clk(clk), .reset(reset), .en(flush | pc_write), .clr(1'b0),
    .d(pc_d), .q(pc_q)
  );

  assign ifid_d = '{instr: imem_instr, pc: pc_plus4, valid: 1'b1};

  // Flush clears to all-zero, which is the NOP/invalid encoding.
  pipe_reg #(.W($bits(ifid_t))) u_ifid (
    .clk(clk), .reset(reset), .en(ifid_write), .clr(flush),
    .d(ifid_d), .q(ifid_q)
  );

  assign ifid_rs = REG_W'(ifid_q.instr[RS_HI:RS_LO]);
  assign ifid_rt = REG_W'(ifid_q.instr[RT_HI:RT_LO]);

  assign idex_bubble = flush | stall_insert | ~ifid_q.valid;

  always_comb begin
    idex_d = '{ctrl: id_ctrl, mem_read: id_mem_read, rt: ifid_rt, valid: 1'b1};
    if (idex_bubble)
      idex_d = '{ctrl: CTRL_W'(CTRL_BUBBLE), mem_read: 1'b0, rt: '0, valid: 1'b0};
  end

  // ID/EX reloads every cycle; a hazard or empty decode stage feeds a bubble.
  pipe_reg #(.W($bits(idex_t))) u_idex (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
    .d(idex_d), .q(idex_q)
  );

  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign idex_rt       = idex_q.rt;
  assign idex_mem_read = idex_q.mem_read;
  assign idex_ctrl     = idex_q.ctrl;
  assign idex_valid    = idex_q.valid;

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             stall_cnt <= '0;
    else if (stall_insert && ~&stall_cnt)  stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_count = stall_cnt;
`endif
endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Randomized and directed checks of fetch_decode_pipe against a cycle-level
// reference model; stall counter checks apply when STALL_COUNTER_EN is set.
module tb_fetch_decode_pipe;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 0;
  logic        reset, pc_write, ifid_write, stall_insert, flush;
  logic [31:0] branch_target, imem_addr, imem_instr, ifid_instr, ifid_pc;
  logic [7:0]  id_ctrl, ifid_rs, ifid_rt, idex_rt, idex_ctrl;
  logic        id_mem_read, idex_mem_read, idex_valid;
`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_count;
`endif

  fetch_decode_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_insert(stall_insert), .flush(flush), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
    .idex_mem_read(idex_mem_read), .idex_ctrl(idex_ctrl), .idex_valid(idex_valid)
`ifdef STALL_COUNTER_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: what each stage architecturally holds.
  logic [31:0] m_pc, m_if_instr, m_if_pc;
  logic        m_if_valid;
  logic [7:0]  m_ex_ctrl, m_ex_rt;
  logic        m_ex_mr, m_ex_valid;
  int          m_cnt;

  function automatic logic [7:0] fld(input logic [31:0] instr, input int lo);
    return 8'((instr >> lo) & 32'h1F);
  endfunction

  task automatic model_clear();
    m_pc = 0; m_if_instr = 0; m_if_pc = 0; m_if_valid = 0;
    m_ex_ctrl = 0; m_ex_rt = 0; m_ex_mr = 0; m_ex_valid = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_instr", ifid_instr, m_if_instr);
    chk("ifid_pc", ifid_pc, m_if_pc);
    chk("ifid_rs", ifid_rs, fld(m_if_instr, 21));
    chk("ifid_rt", ifid_rt, fld(m_if_instr, 16));
    chk("idex_ctrl", idex_ctrl, m_ex_ctrl);
    chk("idex_rt", idex_rt, m_ex_rt);
    chk("idex_mem_read", idex_mem_read, m_ex_mr);
    chk("idex_valid", idex_valid, m_ex_valid);
`ifdef STALL_COUNTER_EN
    chk("stall_count", stall_count, m_cnt);
`endif
  endtask

  // Advance one clock: next state from the rules, then compare everything.
  task automatic tick();
    logic [31:0] n_pc, n_ii, n_ip;
    logic        n_iv, n_em, n_ev;
    logic [7:0]  n_ec, n_er;
    int          n_cnt;
    n_pc = m_pc; n_ii = m_if_instr; n_ip = m_if_pc; n_iv = m_if_valid;
    n_ec = 0; n_er = 0; n_em = 0; n_ev = 0; n_cnt = m_cnt;
    if (flush) n_pc = branch_target;
    else if (pc_write) n_pc = m_pc + 32'd4;
    if (flush) begin n_ii = 0; n_ip = 0; n_iv = 0; end
    else if (ifid_write) begin n_ii = imem_instr; n_ip = m_pc + 32'd4; n_iv = 1; end
    if (!(flush || stall_insert || !m_if_valid)) begin
      n_ec = id_ctrl; n_em = id_mem_read; n_er = fld(m_if_instr, 16); n_ev = 1;
    end
    if (stall_insert && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
    @(posedge clk); #1;
    if (reset) model_clear();
    else begin
      m_pc = n_pc; m_if_instr = n_ii; m_if_pc = n_ip; m_if_valid = n_iv;
      m_ex_ctrl = n_ec; m_ex_rt = n_er; m_ex_mr = n_em; m_ex_valid = n_ev;
      m_cnt = n_cnt;
    end
    check_all();
  endtask

  task automatic drive(input logic pw, input logic iw, input logic si, input logic fl);
    pc_write = pw; ifid_write = iw; stall_insert = si; flush = fl;
  endtask

  logic [31:0] sv_pc, sv_instr;
  int          sv_cnt;

  initial begin
    reset = 1; drive(0, 0, 0, 0);
    branch_target = 0; imem_instr = 0; id_ctrl = 0; id_mem_read = 0;
    model_clear();
    #2 check_all();
    @(posedge clk); #1 reset = 0;

    // Free flow with a load instruction
    drive(1, 1, 0, 0);
    imem_instr = 32'h8C0F_0000; id_ctrl = 8'hA5; id_mem_read = 1;
    tick();
    chk("ff_rs", ifid_rs, 8'h00);
    chk("ff_rt", ifid_rt, 8'h0F);
    tick();
    chk("ff_ex_ctrl", idex_ctrl, 8'hA5);
    chk("ff_ex_rt", idex_rt, 8'h0F);
    chk("ff_ex_mr", idex_mem_read, 1'b1);
    chk("ff_ex_valid", idex_valid, 1'b1);

    // Single-cycle load-use stall
    sv_pc = m_pc; sv_instr = m_if_instr; sv_cnt = m_cnt;
    drive(0, 0, 1, 0);
    tick();
    chk("lu_pc_hold", imem_addr, sv_pc);
    chk("lu_ifid_hold", ifid_instr, sv_instr);
    chk("lu_bubble_valid", idex_valid, 1'b0);
    chk("lu_bubble_ctrl", idex_ctrl, 8'h00);
`ifdef STALL_COUNTER_EN
    chk("lu_cnt_inc", stall_count, sv_cnt + 1);
`endif
    drive(1, 1, 0, 0);
    tick();

    // Flush beats stall and a held PC
    drive(0, 0, 1, 1); branch_target = 32'h100;
    tick();
    chk("fl_pc", imem_addr, 32'h100);
    chk("fl_ifid_instr", ifid_instr, 32'h0);
    chk("fl_ex_valid", idex_valid, 1'b0);

    // PC wrap
    drive(0, 0, 0, 1); branch_target = 32'hFFFF_FFFC;
    tick();
    drive(1, 1, 0, 0);
    tick();
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_ifid_pc", ifid_pc, 32'h0);

    // Stall counter saturation
    drive(0, 0, 1, 0);
    repeat (5) tick();
`ifdef STALL_COUNTER_EN
    chk("sat_cnt", stall_count, CNT_MAX);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(7) == 0));
      branch_target = $urandom; imem_instr = $urandom;
      id_ctrl = 8'($urandom); id_mem_read = 1'($urandom);
      tick();
    end

    // Reset in the middle of a stall
    drive(0, 0, 1, 0);
    tick();
    #3 reset = 1;
    #1 model_clear();
    chk("rst_pc", imem_addr, 32'h0);
    check_all();
    tick();
    #3 reset = 0;
    drive(1, 1, 0, 0);
    #1 chk("rel_pc0", imem_addr, 32'h0);
    tick();
    chk("rel_pc4", imem_addr, 32'h4);
    tick();
    chk("rel_pc8", imem_addr, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_decode_pipe.md
# fetch_decode_pipe

Front end of the five-stage pipeline: owns the PC, the IF/ID register and the ID/EX control register. It is the consumer of the hazard detection unit's PC-write, IF/ID-write and stall-insert outputs, and the producer of that unit's register-field and mem-read inputs, which closes the load-use loop. On a detected hazard it holds fetch, holds decode and injects one bubble into execute.

## Interface
- PC_W, 32, PC and address width
- INSTR_W, 32, instruction width
- REG_W, 8, register-ID width presented to the hazard unit (5-bit fields zero-extended)
- CTRL_W, 8, ID/EX control bundle width
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- pc_write  in  1  from hazard unit; 1 = PC may advance
- ifid_write  in  1  from hazard unit; 1 = IF/ID may load
- stall_insert  in  1  from hazard unit; 1 = load bubble into ID/EX
- flush  in  1  taken branch/jump resolved in EX
- branch_target  in  PC_W  redirect address
- imem_addr  out  PC_W  current PC to instruction memory
- imem_instr  in  INSTR_W  combinational fetch data
- id_ctrl  in  CTRL_W  decoder output for ifid_instr
- id_mem_read  in  1  decoder says ifid_instr is a load
- ifid_instr  out  INSTR_W  decode-stage instruction
- ifid_pc  out  PC_W  PC+4 of decode-stage instruction
- ifid_rs, ifid_rt  out  REG_W  instr[25:21], instr[20:16], zero-extended
- idex_rt  out  REG_W  rt of execute-stage instruction
- idex_mem_read  out  1  execute-stage instruction is a load
- idex_ctrl  out  CTRL_W  execute-stage control bundle
- idex_valid  out  1  execute stage holds a real instruction
- stall_count  out  CNT_W  present only with STALL_COUNTER_EN

## Operation
- All state updates on the rising clk edge; reset clears everything asynchronously.
- PC: flush → branch_target; else pc_write → PC+4 (mod 2^PC_W, wraps); else hold.
- IF/ID: flush → instr=0 (NOP), pc=0, valid=0; else ifid_write → {imem_instr, PC+4}, valid=1; else hold.
- ID/EX: flush, stall_insert or !ifid_valid → bubble (ctrl=0, mem_read=0, rt=0, valid=0); else load {id_ctrl, id_mem_read, ifid_rt}, valid=1.
- Priority: reset > flush > enables. Each register obeys its own enable; pc_write=1 with ifid_write=0 is legal and executes literally (the fetched instruction is lost).
- ifid_rs/ifid_rt are combinational slices of the IF/ID register.
- The stall counter increments on every non-reset cycle with stall_insert=1 and saturates at all-ones. Flush does not clear it.

## Timing
- Reset values: PC=0, imem_addr=0, ifid_*=0, idex_*=0, idex_valid=0, stall_count=0.
- One-cycle latency per stage. imem_addr equals PC with no added delay.
- Hazard loop: idex_rt, idex_mem_read, ifid_rs and ifid_rt are registered. The hazard unit is combinational, so its enables are sampled on the same edge they are computed for.
- One load-use stall costs exactly one cycle: the dependent instruction stays in IF/ID for two cycles, with one bubble behind the load.
- Reset asserted mid-stall: all state clears immediately. After release, fetch resumes at address 0.

## Configuration
- STALL_COUNTER_EN defined: the CNT_W counter and the stall_count port exist.
- STALL_COUNTER_EN undefined: the counter logic and the stall_count port are both absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR = 0
  - PC_INC = 4
  - RS_HI/RS_LO = 25/21, RT_HI/RT_LO = 20/16
  - bubble control constant CTRL_BUBBLE = 0
- One sub-module, pipe_reg: parameterised width, enable, synchronous clear, async active-high reset. It is instantiated for the PC, IF/ID and ID/EX registers.

## Test plan
- Reset: assert reset mid-run → all outputs 0 at once. Release → imem_addr = 0, 4, 8 on successive edges.
- Free flow: enables 1, stall 0, imem_instr = 0x8C0F0000, id_ctrl = 0xA5, id_mem_read = 1 → next edge ifid_rs = 0x00, ifid_rt = 0x0F; following edge idex_ctrl = 0xA5, idex_rt = 0x0F, idex_mem_read = 1, idex_valid = 1.
- Load-use: one cycle of pc_write = 0, ifid_write = 0, stall_insert = 1 → PC and IF/ID unchanged, ID/EX is bubble (ctrl = 0, mem_read = 0, valid = 0), stall_count increases by 1.
- Flush concurrent with stall_insert = 1 and pc_write = 0, branch_target = 0x100 → PC = 0x100, IF/ID = NOP/invalid, ID/EX = bubble.
- PC wrap: force PC to 0xFFFFFFFC, pc_write = 1 → PC = 0x00000000.
- With CNT_W = 2 and STALL_COUNTER_EN: hold stall_insert for 5 cycles → stall_count = 3 and stays there. Without the macro, the bench compiles without stall_count.
